// File: rtl/mul_arbiter.sv
// Two-requester arbiter in front of one shared shift-add multiplier (IDLE/LOAD/RUN/DONE).
// Latency: request sampled in IDLE cycle t -> one-cycle done pulse in cycle t+DW+3.
// Backpressure: req is a level held until done; a job cannot be interrupted except by reset.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req[1:0]          level requests; a0/b0 and a1/b1 are the matching operands
//   done[1:0]         registered one-hot completion pulse to the served requester
//   res               product of the last completed job, held until the next completion
//   busy, grant_id    FSM not idle; index of the current or last served requester
//   mul_en            multiplier control: 0 loads it, 1 steps it
//   mul_a, mul_b      operands latched at grant; mul_c is the multiplier product
// Build option: define MUL_ARB_RR_EN for round-robin tie breaking; otherwise requester 0
// always wins a tie.
module mul_arbiter #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req,
  input  logic [DW-1:0]   a0,
  input  logic [DW-1:0]   b0,
  input  logic [DW-1:0]   a1,
  input  logic [DW-1:0]   b1,
  output logic [1:0]      done,
  output logic [2*DW-1:0] res,
  output logic            busy,
  output logic            grant_id,
  output logic            mul_en,
  output logic [DW-1:0]   mul_a,
  output logic [DW-1:0]   mul_b,
  input  logic [2*DW-1:0] mul_c
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   mul_a_q, mul_a_d;
  logic [DW-1:0]   mul_b_q, mul_b_d;
  logic            grant_q, grant_d;
  logic [2*DW-1:0] res_q, res_d;
  logic [1:0]      done_q, done_d;

  logic [1:0]      elig;
  logic            win;

  // A requester whose done pulse is showing this cycle is still holding req for
  // the job that just finished, so it must not be granted again off that level.
  assign elig = req & ~done_q;

`ifdef MUL_ARB_RR_EN
  logic rr_last_q, rr_last_d;

  always_comb begin
    if (elig == 2'b11) win = ~rr_last_q;
    else               win = ~elig[0];
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (state_q == IDLE && elig != 2'b00) rr_last_d = win;
  end

  // Starts as "requester 1 served last" so requester 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) rr_last_q <= 1'b1;
    else       rr_last_q <= rr_last_d;
  end
`else
  always_comb begin
    win = ~elig[0];
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (elig != 2'b00) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy   = (state_q != IDLE);
    mul_en = (state_q == RUN) || (state_q == DONE);
  end

  // Datapath: operands only move at grant; done is a single-cycle pulse.
  always_comb begin
    cnt_d   = cnt_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    grant_d = grant_q;
    res_d   = res_q;
    done_d  = 2'b00;
    case (state_q)
      IDLE: begin
        if (elig != 2'b00) begin
          grant_d = win;
          mul_a_d = win ? a1 : a0;
          mul_b_d = win ? b1 : b0;
        end
      end
      LOAD: cnt_d = CW'(DW - 1);
      RUN: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      DONE: begin
        res_d           = mul_c;
        done_d[grant_q] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      grant_q <= 1'b0;
      res_q   <= '0;
      done_q  <= 2'b00;
    end else begin
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      grant_q <= grant_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign done     = done_q;
  assign res      = res_q;
  assign grant_id = grant_q;
  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;

endmodule
